// File: rtl/prim_fifo_arb_sync.sv
// prim_fifo_arb_sync
// Synchronous FIFO with two write requesters sharing one write port through a
// round-robin arbiter, and a single read port.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (pointers and priority only)
//   clr_i        synchronous flush: pointers and priority return to 0
//   wvalid0_i/1  write request from requester 0 / 1
//   wdata0_i/1   write data from requester 0 / 1
//   wready0_o/1  write grant to requester 0 / 1
//   rvalid_o     head entry available
//   rready_i     consumer pops the head entry
//   rdata_o      head entry data
//   full_o       FIFO holds Depth entries
//   depth_o      current occupancy, 0..Depth
//   err_o        a pointer index is outside 0..Depth-1
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. wready_k is combinational from wvalid_k, the pointers, prio and
// clr_i; it never looks at rready_i, so a full FIFO refuses writes even when a
// pop happens in the same cycle. rvalid_o never depends on rready_i.
module prim_fifo_arb_sync #(
  parameter int Depth = 4,
  parameter int Width = 16,
  localparam int PtrW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid0_i,
  input  logic [Width-1:0] wdata0_i,
  output logic             wready0_o,
  input  logic             wvalid1_i,
  input  logic [Width-1:0] wdata1_i,
  output logic             wready1_o,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic [PtrW-1:0]  depth_o,
  output logic             err_o
);

  localparam int IdxW = PtrW - 1;

  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic             prio;
  logic [Width-1:0] mem [Depth];

  logic [IdxW-1:0]  w_idx;
  logic [IdxW-1:0]  r_idx;
  logic             w_wrap;
  logic             r_wrap;
  logic             empty;
  logic             full;
  logic             can_wr;
  logic             wr_en;
  logic [Width-1:0] wr_data;
  logic             pop;

  assign w_idx  = wptr[IdxW-1:0];
  assign r_idx  = rptr[IdxW-1:0];
  assign w_wrap = wptr[PtrW-1];
  assign r_wrap = rptr[PtrW-1];

  // Index wraps at Depth-1 (not at a power of two), toggling the wrap bit.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p[IdxW-1:0] == IdxW'(Depth - 1)) begin
      return {~p[PtrW-1], {IdxW{1'b0}}};
    end
    return {p[PtrW-1], p[IdxW-1:0] + IdxW'(1)};
  endfunction

  assign empty = (wptr == rptr);
  assign full  = (w_idx == r_idx) && (w_wrap != r_wrap);

  always_comb begin
    depth_o = '0;
    if (w_wrap == r_wrap) begin
      depth_o = PtrW'(w_idx) - PtrW'(r_idx);
    end else begin
      depth_o = PtrW'(Depth) - PtrW'(r_idx) + PtrW'(w_idx);
    end
  end

  assign full_o = full;

  // Indices are widened before comparing so the check stays meaningful for
  // non-power-of-2 depths, where an index field can hold values >= Depth.
  assign err_o = (32'(w_idx) > 32'(Depth - 1)) || (32'(r_idx) > 32'(Depth - 1));

  // Round-robin grant: a lone requester always wins; on contention prio
  // picks the winner (0 favours requester 0).
  assign can_wr    = !full && !clr_i;
  assign wready0_o = can_wr && wvalid0_i && (!wvalid1_i || !prio);
  assign wready1_o = can_wr && wvalid1_i && (!wvalid0_i || prio);
  assign wr_en     = wready0_o || wready1_o;
  assign wr_data   = wready1_o ? wdata1_i : wdata0_i;

  assign rvalid_o = !empty && !clr_i;
  assign pop      = rvalid_o && rready_i;
  assign rdata_o  = mem[r_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      prio <= 1'b0;
    end else if (clr_i) begin
      wptr <= '0;
      rptr <= '0;
      prio <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= ptr_inc(wptr);
        // The winner loses priority to the other requester.
        prio <= wready0_o;
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
    end
  end

  // Storage is intentionally not reset; clr_i leaves contents in place.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[w_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_prim_fifo_arb_sync.sv
// Bench for prim_fifo_arb_sync: a Depth=4 and a Depth=3 instance share the
// same stimulus; sel chooses which one is checked against the model.
module tb_prim_fifo_arb_sync;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         clr = 1'b0;
  logic         wv0 = 1'b0;
  logic         wv1 = 1'b0;
  logic [W-1:0] wd0 = '0;
  logic [W-1:0] wd1 = '0;
  logic         rr  = 1'b0;
  logic         sel = 1'b0;

  logic         a_wready0, a_wready1, a_rvalid, a_full, a_err;
  logic [W-1:0] a_rdata;
  logic [2:0]   a_depth;
  logic         b_wready0, b_wready1, b_rvalid, b_full, b_err;
  logic [W-1:0] b_rdata;
  logic [2:0]   b_depth;

  prim_fifo_arb_sync #(.Depth(4), .Width(W)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .wvalid0_i(wv0), .wdata0_i(wd0), .wready0_o(a_wready0),
    .wvalid1_i(wv1), .wdata1_i(wd1), .wready1_o(a_wready1),
    .rvalid_o(a_rvalid), .rready_i(rr), .rdata_o(a_rdata),
    .full_o(a_full), .depth_o(a_depth), .err_o(a_err)
  );

  prim_fifo_arb_sync #(.Depth(3), .Width(W)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .wvalid0_i(wv0), .wdata0_i(wd0), .wready0_o(b_wready0),
    .wvalid1_i(wv1), .wdata1_i(wd1), .wready1_o(b_wready1),
    .rvalid_o(b_rvalid), .rready_i(rr), .rdata_o(b_rdata),
    .full_o(b_full), .depth_o(b_depth), .err_o(b_err)
  );

  logic         o_wready0, o_wready1, o_rvalid, o_full, o_err;
  logic [W-1:0] o_rdata;
  logic [2:0]   o_depth;

  always_comb begin
    o_wready0 = sel ? b_wready0 : a_wready0;
    o_wready1 = sel ? b_wready1 : a_wready1;
    o_rvalid  = sel ? b_rvalid  : a_rvalid;
    o_rdata   = sel ? b_rdata   : a_rdata;
    o_full    = sel ? b_full    : a_full;
    o_depth   = sel ? b_depth   : a_depth;
    o_err     = sel ? b_err     : a_err;
  end

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic         m_prio = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called right after a falling edge with inputs already driven: checks the
  // combinational outputs, advances the model across the next rising edge,
  // and returns at the following falling edge.
  task automatic tick();
    int   cnt;
    int   dmax;
    logic exp_g0, exp_g1, exp_rv, exp_full;
    #1;
    dmax     = sel ? 3 : 4;
    cnt      = exp_q.size();
    exp_full = (cnt == dmax);
    exp_g0   = 1'b0;
    exp_g1   = 1'b0;
    if (!clr && !exp_full) begin
      if (wv0 && wv1) begin
        if (m_prio) exp_g1 = 1'b1;
        else        exp_g0 = 1'b1;
      end else if (wv0) begin
        exp_g0 = 1'b1;
      end else if (wv1) begin
        exp_g1 = 1'b1;
      end
    end
    exp_rv = (cnt != 0) && !clr;
    chk("wready0", 32'(o_wready0), 32'(exp_g0));
    chk("wready1", 32'(o_wready1), 32'(exp_g1));
    chk("rvalid",  32'(o_rvalid),  32'(exp_rv));
    chk("full",    32'(o_full),    32'(exp_full));
    chk("depth",   32'(o_depth),   32'(cnt));
    chk("err",     32'(o_err),     32'd0);
    if (exp_rv) chk("rdata", 32'(o_rdata), 32'(exp_q[0]));
    @(posedge clk);
    if (clr) begin
      exp_q.delete();
      m_prio = 1'b0;
    end else begin
      if (exp_rv && rr) void'(exp_q.pop_front());
      if (exp_g0) begin
        exp_q.push_back(wd0);
        m_prio = 1'b1;
      end else if (exp_g1) begin
        exp_q.push_back(wd1);
        m_prio = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1, input logic r);
    clr = c; wv0 = v0; wd0 = d0; wv1 = v1; wd1 = d1; rr = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    m_prio = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_full",   32'(o_full),   32'd0);
    chk("rst_depth",  32'(o_depth),  32'd0);
    chk("rst_err",    32'(o_err),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Depth=4 instance
    sel = 1'b0;
    do_reset();

    // Both requesters contend from reset: grants alternate 0,1,0,1, then full.
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b1, W'(16'hA000 + n), 1'b1, W'(16'hB000 + n), 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 16'hA004, 1'b1, 16'hB004, 1'b0);
    tick();

    // Full with a pop in the same cycle: no write-through, then write accepted.
    drive(1'b0, 1'b1, 16'hA005, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 16'hA006, 1'b0, '0, 1'b0);
    tick();

    // Drain.
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      tick();
    end

    // Write-to-read latency with rready held high.
    drive(1'b0, 1'b1, 16'h1234, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    tick();
    tick();

    // Random traffic with occasional flushes.
    for (int n = 0; n < 300; n++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      clr = ($urandom_range(0, 29) == 0);
      wv0 = ($urandom_range(0, 2) != 0);
      wv1 = ($urandom_range(0, 2) != 0);
      wd0 = W'($urandom_range(0, 65535));
      wd1 = W'($urandom_range(0, 65535));
      rr  = ($urandom_range(0, 1) != 0);
      tick();
    end

    // Flush with both requesters valid at depth 2.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 16'h0C01, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 16'h0C02, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'h0C03, 1'b1, 16'h0C04, 1'b0);
    tick();
    drive(1'b0, 1'b1, 16'h0C05, 1'b1, 16'h0C06, 1'b0);
    tick();

    // Asynchronous reset between edges with three entries stored.
    drive(1'b0, 1'b1, 16'h0D01, 1'b0, '0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("pre_async_depth", 32'(o_depth), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rvalid", 32'(o_rvalid), 32'd0);
    chk("async_full",   32'(o_full),   32'd0);
    chk("async_depth",  32'(o_depth),  32'd0);
    chk("async_err",    32'(o_err),    32'd0);
    exp_q.delete();
    m_prio = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // First cycle after release: empty, requester 0 favoured.
    drive(1'b0, 1'b1, 16'h0E01, 1'b1, 16'h0E02, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    tick();
    tick();

    // Depth=3 instance: interleaved writes and pops across the index wrap.
    sel = 1'b1;
    do_reset();
    drive(1'b0, 1'b1, 16'h3000, 1'b0, '0, 1'b0);
    tick();
    for (int n = 1; n < 7; n++) begin
      drive(1'b0, 1'b1, W'(16'h3000 + n), 1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    tick();
    tick();

    for (int n = 0; n < 200; n++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      clr = ($urandom_range(0, 39) == 0);
      wv0 = ($urandom_range(0, 2) != 0);
      wv1 = ($urandom_range(0, 2) != 0);
      wd0 = W'($urandom_range(0, 65535));
      wd1 = W'($urandom_range(0, 65535));
      rr  = ($urandom_range(0, 1) != 0);
      tick();
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prim_fifo_arb_sync.md
PRIM_FIFO_ARB_SYNC -- requirements
Module: prim_fifo_arb_sync

Interface
REQ-001 SHALL have parameter Depth, default 4, number of storage entries; legal values are 2 or greater, and non-power-of-2 values are legal.
REQ-002 SHALL have parameter Width, default 16, data width in bits; legal values are 1 or greater.
REQ-003 SHALL have derived localparam PtrW = $clog2(Depth)+1, which is the pointer width including the wrap bit.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clr_i  input  1  synchronous flush of FIFO state.
REQ-007 SHALL have ports wvalid0_i / wvalid1_i  input  1  write request from requester 0 / 1.
REQ-008 SHALL have ports wdata0_i / wdata1_i  input  Width  write data from requester 0 / 1.
REQ-009 SHALL have ports wready0_o / wready1_o  output  1  write grant to requester 0 / 1; data is accepted when valid and ready are both high.
REQ-010 SHALL have port rvalid_o  output  1  head entry available.
REQ-011 SHALL have port rready_i  input  1  consumer pops the head entry.
REQ-012 SHALL have port rdata_o  output  Width  head entry data.
REQ-013 SHALL have port full_o  output  1  FIFO holds Depth entries.
REQ-014 SHALL have port depth_o  output  PtrW  current occupancy, range 0..Depth.
REQ-015 SHALL have port err_o  output  1  pointer integrity error.

Function
REQ-016 SHALL hold write pointer wptr and read pointer rptr, each PtrW bits: low bits are the index, MSB is the wrap bit.
REQ-017 On increment, a pointer whose index equals Depth-1 SHALL reset its index to 0 and toggle its wrap bit; otherwise the index SHALL increment by 1.
REQ-018 SHALL define empty as wptr == rptr, and full as equal indices with differing wrap bits.
REQ-019 depth_o SHALL equal (wptr index - rptr index) when the wrap bits are equal, and Depth - rptr index + wptr index when they differ.
REQ-020 Arbitration SHALL be round-robin using a 1-bit priority register prio, where 0 means requester 0 is favoured.
REQ-021 When not full and only one requester is valid, that requester SHALL be granted.
REQ-022 When not full and both requesters are valid, the requester indicated by prio SHALL be granted.
REQ-023 At most one wready SHALL be high in any cycle.
REQ-024 wready_k SHALL be combinational, and SHALL depend on wvalid_k (never on itself or on rready_i).
REQ-025 After an accepted write by requester k, prio SHALL become ~k on the next edge; with no accepted write, prio SHALL hold.
REQ-026 An accepted write SHALL store the granted wdata at the wptr index and increment wptr at the same edge.
REQ-027 When full, both wready outputs SHALL be 0, even if rready_i is high in that cycle; there is no write-through on full.
REQ-028 rvalid_o SHALL equal !empty; rdata_o SHALL be the storage entry at the rptr index, driven combinationally.
REQ-029 A pop (rvalid_o & rready_i) SHALL increment rptr; rready_i while empty SHALL be ignored.
REQ-030 Write-to-read latency SHALL be 1 cycle: data written at edge N is visible on rvalid_o/rdata_o after edge N; there is no fall-through.
REQ-031 A simultaneous accepted write and pop SHALL leave depth_o unchanged and advance both pointers.
REQ-032 full_o SHALL be asserted exactly when depth_o == Depth.
REQ-033 clr_i SHALL take priority over all handshakes; while clr_i is high, wready0_o, wready1_o and rvalid_o SHALL be 0.
REQ-034 At the clock edge where clr_i is high, wptr, rptr and prio SHALL be set to 0; storage contents SHALL be left unchanged.
REQ-035 err_o SHALL be combinational and SHALL be 1 when either pointer index exceeds Depth-1; otherwise it SHALL be 0.

Reset
REQ-036 While rst_ni is low, asynchronously: wptr=0, rptr=0, prio=0; so rvalid_o=0, full_o=0, depth_o=0, err_o=0.
REQ-037 Storage SHALL NOT be reset; rdata_o is don't-care while rvalid_o=0.
REQ-038 Reset asserted mid-transfer SHALL discard all entries; the first cycle after release SHALL present an empty FIFO with prio=0.

Verification (Depth=4, Width=16)
REQ-039 Both requesters valid for 4 cycles from reset, wdata0=0xA000+n, wdata1=0xB000+n, no reads -> grants alternate 0,1,0,1; full_o=1 and depth_o=4 after the 4th edge; both wready=0 afterwards.
REQ-040 Full FIFO, rready_i=1 and wvalid0_i=1 in the same cycle -> wready0_o=0, one pop occurs, depth_o=3; the next cycle wready0_o=1.
REQ-041 Depth=3 build: 7 writes interleaved with 7 pops -> pointer indices wrap 2->0 with the wrap bit toggling; data order is preserved; err_o never 1.
REQ-042 Empty FIFO, write 0x1234 at edge N with rready_i held at 1 -> rvalid_o=0 before edge N, and rvalid_o=1 with rdata_o=0x1234 after edge N, popped at edge N+1.
REQ-043 depth_o=2, clr_i pulsed for 1 cycle with both requesters valid -> no grant in that cycle; after the edge depth_o=0, rvalid_o=0, prio=0.
REQ-044 rst_ni dropped asynchronously between edges with depth_o=3 -> outputs reach reset values immediately, without waiting for a clock edge.
